// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF       = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter must hold the longest latency value.
  function automatic int unsigned cnt_width(input int unsigned m, input int unsigned d);
    return $clog2(((m > d) ? m : d) + 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// E-stage / hazard-unit side bundle of the HI/LO multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             d_md_use;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, d_md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, d_md_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU,
// including divide-by-zero and signed-overflow special cases.
module muldiv_arith
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]           prod_s;
  logic [PW-1:0]           prod_u;
  logic                    b_zero;
  logic                    s_ovf;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sdiv;
  logic signed [WIDTH-1:0] sq;
  logic signed [WIDTH-1:0] sr;
  logic [WIDTH-1:0]        udiv;
  logic [WIDTH-1:0]        uq;
  logic [WIDTH-1:0]        ur;

  // Low 2W bits of the sign-extended product equal the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign b_zero = (b == '0);
  assign s_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // Divisors are forced to 1 in the special cases so the dividers never see them.
  assign sa   = $signed(a);
  assign sdiv = (b_zero || s_ovf) ? $signed(WIDTH'(1)) : $signed(b);
  assign sq   = sa / sdiv;
  assign sr   = sa % sdiv;
  assign udiv = b_zero ? WIDTH'(1) : b;
  assign uq   = a / udiv;
  assign ur   = a % udiv;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = '1;
        end else if (s_ovf) begin
          res_hi = '0;
          res_lo = a;
        end else begin
          res_hi = WIDTH'(sr);
          res_lo = WIDTH'(sq);
        end
      end
      OP_DIVU: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: busy counter, HI/LO ownership and
// D-stage stall request for the pipelined MIPS core.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);
  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             is_long;
  logic             issue;
  logic             last;

  muldiv_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (bus.op),
    .a      (bus.rs_val),
    .b      (bus.rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign is_long  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign issue    = (state == IDLE) && bus.start && is_long;
  assign last     = (state == RUN) && (cnt == CNT_W'(1));
  assign cnt_load = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                                : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stall covers both the in-flight window and the issue cycle itself.
  always_comb begin
    bus.busy  = 1'b0;
    bus.stall = 1'b0;
    if (state == RUN) bus.busy = 1'b1;
    bus.stall = bus.d_md_use & ((state == RUN) | bus.start);
  end

  // Starts seen in RUN are dropped; HI/LO only move on completion or MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (state == RUN) begin
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else if (bus.start) begin
      if (is_long) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= cnt_load;
      end else if (bus.op == OP_MTHI) begin
        hi_q <= bus.rs_val;
      end else if (bus.op == OP_MTLO) begin
        lo_q <= bus.rs_val;
      end
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource of the pipelined MIPS core. It sits beside the E-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E.
- Models the multi-cycle latency with a busy counter and owns the HI/LO registers.
- Raises a stall request to the hazard unit when a D-stage instruction touches HI/LO while the unit is occupied.

Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  E-stage holds a valid, non-stalled HI/LO-writing instruction this cycle
- op  in  3  operation code (muldiv_pkg)
- rs_val  in  WIDTH  operand A (forwarded rs)
- rt_val  in  WIDTH  operand B (forwarded rt)
- d_md_use  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
- busy  out  1  multi-cycle operation in progress
- stall  out  1  stall request to the hazard unit
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous, at any time including mid-operation):
  - state=IDLE, counter=0, pending results=0.
  - hi=0, lo=0, busy=0.
  - stall=0, since stall is combinational from busy/start and both are 0 when start is low.
- States:
  - IDLE, busy=0.
  - RUN, busy=1; the counter holds the remaining cycles.
- IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}:
  - The operation is captured at the edge ending start cycle t.
  - At that edge: compute the results, latch them into pending_hi/pending_lo, load counter=N (MULT_CYCLES or DIV_CYCLES), go to RUN.
  - busy=1 in cycles t+1 .. t+N.
  - At the edge ending cycle t+N: hi/lo ← pending, go to IDLE.
  - New hi/lo are visible in cycle t+N+1 together with busy=0.
- IDLE with start=1 and op=MTHI: hi ← rs_val at the next edge, lo unchanged, busy stays 0.
- IDLE with start=1 and op=MTLO: lo ← rs_val at the next edge, hi unchanged, busy stays 0.
- start=1 with op=NONE, or an undefined code: no effect.
- start=1 while in RUN: ignored. The pending operation continues unchanged and hi/lo are not written. This is legal only as a hazard-unit bug, because stall prevents it.
- hi/lo are never changed while in RUN until the completion edge.
- stall = d_md_use & (busy | start), combinational.
  - This blocks a D-stage HI/LO instruction from entering E while an operation is in flight or just issuing.
  - This includes the issue cycle of a 1-cycle MTHI/MTLO.
- Arithmetic:
  - MULT: signed 32×32 → 64, hi=[63:32], lo=[31:0].
  - MULTU: the same, unsigned.
  - DIV, signed: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (DIV or DIVU): lo=all-ones, hi=rs_val.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Completion edge and a new start in the same cycle: the start is ignored, because the state is still RUN in that cycle.

Decomposition:
- muldiv_pkg:
  - op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - state enum {IDLE, RUN}.
  - counter width localparam = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Sub-module muldiv_arith: purely combinational.
  - Computes {res_hi, res_lo} from op, rs_val and rt_val.
  - Includes the divide-by-zero and overflow special cases.
  - muldiv_ctrl owns the FSM, the counter and the registers.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=2, start at cycle t → busy=1 for cycles t+1..t+5; at t+6 busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged during t+1..t+5.
- MULTU rs=0xFFFFFFFF, rt=2 → after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234.
- DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy start and stall:
  - MULT issued, then MTLO rs=0xAA with start=1 at the 2nd busy cycle → MTLO ignored; final lo = MULT result; no extra busy cycles.
  - d_md_use=1 during busy → stall=1.
  - d_md_use=1 with busy=0 and start=0 → stall=0.
- Reset mid-operation: DIV started, reset driven low at the 4th busy cycle between edges → busy, hi, lo go to 0 immediately without a clock edge; after release, MTHI rs=0x55 → hi=0x55 next cycle, busy stays 0.
